// File: rtl/rr_arb2_sel.sv
// rr_arb2_sel: two-requester round-robin arbiter that owns the select line of
// the 2:1 mux directly downstream. All outputs are registered so sel and the
// grants never glitch.
//
// state | meaning
// IDLE  | no grant active, sel holds its last value
// G0    | source 0 granted, sel = 0 (mux in0)
// G1    | source 1 granted, sel = 1 (mux in1)
module rr_arb2_sel #(
    parameter int HOLD_MAX = 16,
    localparam int CW = $clog2(HOLD_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          done,
    output logic          sel,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic [CW-1:0] hold_cnt
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic          sel_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          at_max;
    logic          rel;
    logic          grant;

    assign at_max = (hold_cnt == CW'(HOLD_MAX - 1));

    // Next-state, pointer, select and hold counter decision.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        sel_nxt   = sel;
        cnt_nxt   = hold_cnt;
        rel       = 1'b0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? G0 : G1;
                else if (req0)
                    state_nxt = G0;
                else if (req1)
                    state_nxt = G1;
                grant = req0 | req1;
            end
            G0: begin
                rel = done | ~req0 | (at_max & req1);
                if (rel) begin
                    if (req1)
                        state_nxt = G1;
                    else if (req0)
                        state_nxt = G0;
                    else
                        state_nxt = IDLE;
                    grant = req0 | req1;
                end else begin
                    cnt_nxt = at_max ? hold_cnt : hold_cnt + CW'(1);
                end
            end
            G1: begin
                rel = done | ~req1 | (at_max & req0);
                if (rel) begin
                    if (req0)
                        state_nxt = G0;
                    else if (req1)
                        state_nxt = G1;
                    else
                        state_nxt = IDLE;
                    grant = req0 | req1;
                end else begin
                    cnt_nxt = at_max ? hold_cnt : hold_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A new grant (including a re-grant) restarts the hold count and
        // moves the round-robin pointer; sel only moves on a grant.
        if (state_nxt == IDLE)
            cnt_nxt = '0;
        if (grant) begin
            cnt_nxt  = '0;
            last_nxt = (state_nxt == G1);
            sel_nxt  = (state_nxt == G1);
        end
    end

    // State, pointer and all outputs registered; reset acts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            sel      <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            sel      <= sel_nxt;
            gnt0     <= (state_nxt == G0);
            gnt1     <= (state_nxt == G1);
            busy     <= (state_nxt != IDLE);
            hold_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb2_sel.sv
// Bench for rr_arb2_sel with HOLD_MAX = 4. Each vector row is
// {req0, req1, done, gnt0, gnt1, sel, busy, hold_cnt[1:0]}; the expected part
// is queued when the inputs are driven and compared after the clock edge.
module tb_rr_arb2_sel;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       done = 1'b0;
    logic       sel, gnt0, gnt1, busy;
    logic [1:0] hold_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_q[$];
    logic [5:0] got, want;
    wire  [5:0] obs = {gnt0, gnt1, sel, busy, hold_cnt};

    rr_arb2_sel #(.HOLD_MAX(HM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .done     (done),
        .sel      (sel),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got no summary, want completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        {req0, req1, done} = 3'b000;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        {req0, req1, done} = 3'b000;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(6'b000000);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, got, want);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            {req0, req1, done} = 3'b000;
            exp_q.push_back(6'b000000);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_single();
        logic [8:0] v[6] = '{
            9'b100_100100, 9'b100_100101, 9'b100_100110,
            9'b100_100111, 9'b001_000000, 9'b000_000000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {req0, req1, done} = v[i][8:6];
            exp_q.push_back(v[i][5:0]);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_tie_rr();
        logic [8:0] v[9] = '{
            9'b110_100100, 9'b110_100101, 9'b110_100110,
            9'b111_011100, 9'b110_011101, 9'b111_100100,
            9'b010_011100, 9'b000_001000, 9'b001_001000};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            {req0, req1, done} = v[i][8:6];
            exp_q.push_back(v[i][5:0]);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL tie_rr[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    // Starts from IDLE with last = 1: source 0 wins the tie, is preempted
    // after 4 cycles, then source 1 is preempted with done also asserted.
    task automatic test_preempt();
        logic [8:0] v[10] = '{
            9'b110_100100, 9'b110_100101, 9'b110_100110, 9'b110_100111,
            9'b110_011100, 9'b110_011101, 9'b110_011110, 9'b110_011111,
            9'b111_100100, 9'b000_000000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            {req0, req1, done} = v[i][8:6];
            exp_q.push_back(v[i][5:0]);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL preempt[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_saturation();
        logic [8:0] v[23];
        for (int i = 0; i < 20; i++)
            v[i] = {3'b100, 4'b1001, (i < 3) ? 2'(i) : 2'd3};
        v[20] = 9'b101_100100;
        v[21] = 9'b100_100101;
        v[22] = 9'b000_000000;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            {req0, req1, done} = v[i][8:6];
            exp_q.push_back(v[i][5:0]);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] v[2] = '{9'b010_011100, 9'b010_011101};
        logic [8:0] w[2] = '{9'b110_100100, 9'b000_000000};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            {req0, req1, done} = v[i][8:6];
            exp_q.push_back(v[i][5:0]);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL async_pre[%0d]: got %b want %b", i, got, want);
            end
        end
        @(negedge clk);
        {req0, req1, done} = 3'b110;
        exp_q.push_back(6'b000000);
        #1 rst_n = 1'b0;
        #1;
        got = obs; want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_immediate: got %b want %b", got, want);
        end
        exp_q.push_back(6'b000000);
        @(posedge clk); #1;
        got = obs; want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_held: got %b want %b", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            {req0, req1, done} = w[i][8:6];
            exp_q.push_back(w[i][5:0]);
            @(posedge clk); #1;
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL async_post[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie_rr();
        test_preempt();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb2_sel.md
# rr_arb2_sel

Two-requester round-robin arbiter that generates the select for the 2:1 data mux directly downstream of it. It owns the mux `sel` line and issues one-hot grants to the two sources feeding mux inputs `in0`/`in1`. Grants are held until the grantee signals completion, drops its request, or exceeds a hold limit while the other side waits. All outputs are registered, so `sel` never glitches into the mux.

## Interface
- HOLD_MAX, 16: max cycles a grant is held while the other requester waits; legal range ≥ 2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0  in  1  request from source driving mux `in0`
- req1  in  1  request from source driving mux `in1`
- done  in  1  current grantee finished its transfer this cycle; ignored when no grant is active
- sel  out  1  mux select: 0 = `in0`, 1 = `in1`
- gnt0  out  1  grant to source 0
- gnt1  out  1  grant to source 1
- busy  out  1  `gnt0 | gnt1`
- hold_cnt  out  CW  cycles elapsed in the current grant; CW = $clog2(HOLD_MAX)

## Operation
- States: IDLE, G0, G1. Reset state is IDLE.
- Internal pointer `last`: the most recently granted source. Reset value is 1, so source 0 wins the first tie.
- **IDLE**
  - req0 & req1: grant the source ≠ `last`.
  - Only one request: grant that source.
  - No request: stay in IDLE.
- **G0 / G1** (the current source is x, the other is y)
  - Release condition: `done`, or `req_x == 0` (abandon), or (`hold_cnt == HOLD_MAX-1` and `req_y == 1`) (preempt).
  - On release with `req_y == 1`: move directly to Gy with no IDLE bubble.
  - On release with `req_y == 0` and `req_x == 1` (`done` case): re-grant Gx and clear `hold_cnt`.
  - On release with no requests: go to IDLE.
  - No release: stay in Gx.
- `last` updates to the newly granted source on every grant, including a re-grant.
- **hold_cnt**
  - Cleared on every grant entry and in IDLE.
  - Increments by 1 per cycle in G0/G1.
  - Saturates at HOLD_MAX-1 when the other requester is idle. The grant is kept in that case.
- **sel**
  - 0 in G0, 1 in G1.
  - In IDLE, `sel` holds its last value, so the mux input does not toggle while idle.
- `gnt0` and `gnt1` are never both 1.

## Timing
- Request-to-grant latency is 1 cycle: a `req` sampled at edge N gives `gnt` high after edge N.
- Release latency is 1 cycle: `done` sampled at edge N causes `gnt` to change after edge N.
- `sel`, `gnt0`, `gnt1`, `busy` and `hold_cnt` all update on the same edge and come from registers (no combinational paths from inputs).
- Handover G0→G1 (and G1→G0) happens in a single edge: `gnt0` falls, `gnt1` rises and `sel` goes 1 simultaneously.
- Preempt timing: the grant switches on the edge at which `hold_cnt == HOLD_MAX-1` is sampled with the other request high. The grant therefore lasts exactly HOLD_MAX cycles.
- Simultaneous `done` and preempt condition: treated as one release (same next state).
- `done` in IDLE: ignored, no state change.
- Reset assertion at any time takes effect immediately, without waiting for a clock edge:
  - `gnt0 = gnt1 = busy = 0`
  - `sel = 0`
  - `hold_cnt = 0`
  - `last = 1`
  - state = IDLE
- Reset deassertion: the first grant can occur on the first clock edge after `rst_n` rises.

## Test plan
- **Reset:** hold `rst_n = 0` for 3 cycles, then release with no requests → all outputs 0 and the block stays in IDLE for 5 cycles.
- **Single requester:** `req0 = 1` at edge 0 → `gnt0 = 1`, `sel = 0`, `busy = 1` after edge 0. Pulse `done` at edge 4 with `req0 = 0` → `gnt0 = 0`, `busy = 0` after edge 4, `sel` stays 0.
- **Tie and round-robin:** `req0 = req1 = 1` out of reset → `gnt0` first. `done` at edge 3 → `gnt1 = 1`, `sel = 1` after edge 3 with no idle cycle. Next `done` → `gnt0` again.
- **Preempt:** HOLD_MAX = 4, `req0` held with no `done`, `req1 = 1` → `hold_cnt` steps 0,1,2,3, then `gnt1 = 1`, `sel = 1`, `hold_cnt = 0` on the following edge.
- **Saturation and abandon:** `req0` alone for 20 cycles → `gnt0` stays 1 and `hold_cnt` sticks at HOLD_MAX-1. Drop `req0` without `done` → IDLE after the next edge.
- **Async reset mid-grant:** in G1, pull `rst_n` low between clock edges → all outputs 0 immediately. After release, tied requests grant source 0 first.
